// File: rtl/read_channel_controller.sv
// AXI4 read-side interconnect control path, 2 masters x 4 slaves.
// Arbitrates AR requests, decodes address windows, tracks one burst.
module read_channel_controller (
    input  logic        clkk,
    input  logic        resett,
    input  logic [31:0] slave0_addr1,
    input  logic [31:0] slave0_addr2,
    input  logic [31:0] slave1_addr1,
    input  logic [31:0] slave1_addr2,
    input  logic [31:0] slave2_addr1,
    input  logic [31:0] slave2_addr2,
    input  logic [31:0] slave3_addr1,
    input  logic [31:0] slave3_addr2,
    input  logic [31:0] M_ADDR,
    input  logic        M0_ARVALID,
    input  logic        M1_ARVALID,
    input  logic        M0_RREADY,
    input  logic        M1_RREADY,
    input  logic        S0_ARREADY,
    input  logic        S1_ARREADY,
    input  logic        S2_ARREADY,
    input  logic        S3_ARREADY,
    input  logic        S0_RVALID,
    input  logic        S1_RVALID,
    input  logic        S2_RVALID,
    input  logic        S3_RVALID,
    input  logic        S0_RLAST,
    input  logic        S1_RLAST,
    input  logic        S2_RLAST,
    input  logic        S3_RLAST,
    output logic        select_master_address,
    output logic [1:0]  select_slave_address,
    output logic [1:0]  select_data_M0,
    output logic [1:0]  select_data_M1,
    output logic [1:0]  en_S0,
    output logic [1:0]  en_S1,
    output logic [1:0]  en_S2,
    output logic [1:0]  en_S3
);

    localparam logic [2:0] IDLE   = 3'b000;
    localparam logic [2:0] SLAVE0 = 3'b001;
    localparam logic [2:0] SLAVE1 = 3'b010;
    localparam logic [2:0] SLAVE2 = 3'b011;
    localparam logic [2:0] SLAVE3 = 3'b100;

    logic [2:0]  curr_state_slave;
    logic [2:0]  next_state_slave;
    logic        r_owner;
    logic        w_owner_next;

    logic [31:0] w_lo [4];
    logic [31:0] w_hi [4];
    logic [3:0]  w_arready;
    logic [3:0]  w_rvalid;
    logic [3:0]  w_rlast;
    logic [3:0]  w_match;
    logic        w_hit;
    logic [1:0]  w_idx;
    logic        w_req;
    logic        w_winner;
    logic        w_active;
    logic [1:0]  w_k;
    logic        w_owner_rready;
    logic [1:0]  w_en_code;

    assign w_lo[0] = slave0_addr1;
    assign w_lo[1] = slave1_addr1;
    assign w_lo[2] = slave2_addr1;
    assign w_lo[3] = slave3_addr1;
    assign w_hi[0] = slave0_addr2;
    assign w_hi[1] = slave1_addr2;
    assign w_hi[2] = slave2_addr2;
    assign w_hi[3] = slave3_addr2;

    assign w_arready = {S3_ARREADY, S2_ARREADY, S1_ARREADY, S0_ARREADY};
    assign w_rvalid  = {S3_RVALID, S2_RVALID, S1_RVALID, S0_RVALID};
    assign w_rlast   = {S3_RLAST, S2_RLAST, S1_RLAST, S0_RLAST};

    // Fixed priority: M0 beats M1 whenever both request.
    assign w_req    = M0_ARVALID | M1_ARVALID;
    assign w_winner = ~M0_ARVALID & M1_ARVALID;

    // Window compare, inclusive bounds, unsigned.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_match[k] = (M_ADDR >= w_lo[k]) && (M_ADDR <= w_hi[k]);
        end
    end

    // Lowest matching window wins on overlap.
    always_comb begin
        w_hit = 1'b0;
        w_idx = 2'b00;
        for (int k = 3; k >= 0; k--) begin
            if (w_match[k]) begin
                w_hit = 1'b1;
                w_idx = 2'(k);
            end
        end
    end

    // Map a burst state to its slave index; unused codes are not active.
    always_comb begin
        w_active = 1'b1;
        w_k      = 2'b00;
        case (curr_state_slave)
            SLAVE0:  w_k = 2'b00;
            SLAVE1:  w_k = 2'b01;
            SLAVE2:  w_k = 2'b10;
            SLAVE3:  w_k = 2'b11;
            default: w_active = 1'b0;
        endcase
    end

    assign w_owner_rready = r_owner ? M1_RREADY : M0_RREADY;
    assign w_en_code      = r_owner ? 2'b10 : 2'b01;

    // Next-state: accept on AR handshake, release on last-beat handshake.
    always_comb begin
        next_state_slave = IDLE;
        w_owner_next     = r_owner;
        if (w_active) begin
            next_state_slave = curr_state_slave;
            if (w_rvalid[w_k] && w_rlast[w_k] && w_owner_rready) begin
                next_state_slave = IDLE;
            end
        end else if (curr_state_slave == IDLE) begin
            if (w_req && w_hit && w_arready[w_idx]) begin
                next_state_slave = {1'b0, w_idx} + 3'd1;
                w_owner_next     = w_winner;
            end
        end
    end

    // State and owner registers; reset abandons any burst.
    always_ff @(posedge clkk) begin
        if (resett) begin
            curr_state_slave <= IDLE;
            r_owner          <= 1'b0;
        end else begin
            curr_state_slave <= next_state_slave;
            r_owner          <= w_owner_next;
        end
    end

    // Mux and route selects for the datapath.
    always_comb begin
        select_master_address = 1'b0;
        select_slave_address  = 2'b00;
        select_data_M0        = 2'b00;
        select_data_M1        = 2'b00;
        en_S0                 = 2'b00;
        en_S1                 = 2'b00;
        en_S2                 = 2'b00;
        en_S3                 = 2'b00;
        if (w_active) begin
            select_master_address = r_owner;
            select_slave_address  = w_k;
            if (r_owner) begin
                select_data_M1 = w_k;
            end else begin
                select_data_M0 = w_k;
            end
            case (w_k)
                2'b00:   en_S0 = w_en_code;
                2'b01:   en_S1 = w_en_code;
                2'b10:   en_S2 = w_en_code;
                default: en_S3 = w_en_code;
            endcase
        end else if (w_req) begin
            select_master_address = w_winner;
            select_slave_address  = w_hit ? w_idx : 2'b00;
        end
    end

endmodule

// File: tb/tb_read_channel_controller.sv
// Directed bench for read_channel_controller.
// Table of pre-edge vectors plus short hand sequences.
module tb_read_channel_controller;

    logic        clkk = 1'b0;
    logic        resett;
    logic [31:0] lo0, hi0, lo1, hi1, lo2, hi2, lo3, hi3;
    logic [31:0] M_ADDR;
    logic        M0_ARVALID, M1_ARVALID, M0_RREADY, M1_RREADY;
    logic [3:0]  arr, rv, rl;
    logic        select_master_address;
    logic [1:0]  select_slave_address, select_data_M0, select_data_M1;
    logic [1:0]  en_S0, en_S1, en_S2, en_S3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clkk = ~clkk;

    read_channel_controller dut (
        .clkk(clkk), .resett(resett),
        .slave0_addr1(lo0), .slave0_addr2(hi0),
        .slave1_addr1(lo1), .slave1_addr2(hi1),
        .slave2_addr1(lo2), .slave2_addr2(hi2),
        .slave3_addr1(lo3), .slave3_addr2(hi3),
        .M_ADDR(M_ADDR),
        .M0_ARVALID(M0_ARVALID), .M1_ARVALID(M1_ARVALID),
        .M0_RREADY(M0_RREADY), .M1_RREADY(M1_RREADY),
        .S0_ARREADY(arr[0]), .S1_ARREADY(arr[1]),
        .S2_ARREADY(arr[2]), .S3_ARREADY(arr[3]),
        .S0_RVALID(rv[0]), .S1_RVALID(rv[1]),
        .S2_RVALID(rv[2]), .S3_RVALID(rv[3]),
        .S0_RLAST(rl[0]), .S1_RLAST(rl[1]),
        .S2_RLAST(rl[2]), .S3_RLAST(rl[3]),
        .select_master_address(select_master_address),
        .select_slave_address(select_slave_address),
        .select_data_M0(select_data_M0),
        .select_data_M1(select_data_M1),
        .en_S0(en_S0), .en_S1(en_S1), .en_S2(en_S2), .en_S3(en_S3)
    );

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic        m0v, m1v, m0r, m1r;
        logic [3:0]  arr, rv, rl;
        logic        sm;
        logic [1:0]  ss, d0, d1;
        logic [7:0]  en;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(
        input logic rst, input logic [31:0] addr,
        input logic m0v, input logic m1v,
        input logic m0r, input logic m1r,
        input logic [3:0] a, input logic [3:0] v,
        input logic [3:0] l, input logic sm,
        input logic [1:0] ss, input logic [1:0] d0,
        input logic [1:0] d1, input logic [7:0] en);
        vec_t t;
        t.rst = rst; t.addr = addr;
        t.m0v = m0v; t.m1v = m1v; t.m0r = m0r; t.m1r = m1r;
        t.arr = a; t.rv = v; t.rl = l;
        t.sm = sm; t.ss = ss; t.d0 = d0; t.d1 = d1; t.en = en;
        return t;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic sm,
        input logic [1:0] ss, input logic [1:0] d0,
        input logic [1:0] d1, input logic [7:0] en);
        chk({tag, " sel_master"}, int'(select_master_address), int'(sm));
        chk({tag, " sel_slave"}, int'(select_slave_address), int'(ss));
        chk({tag, " data_M0"}, int'(select_data_M0), int'(d0));
        chk({tag, " data_M1"}, int'(select_data_M1), int'(d1));
        chk({tag, " en"}, int'({en_S3, en_S2, en_S1, en_S0}), int'(en));
    endtask

    task automatic drive(input logic rst, input logic [31:0] a,
        input logic m0v, input logic m1v, input logic m0r,
        input logic m1r, input logic [3:0] ar,
        input logic [3:0] v, input logic [3:0] l);
        resett = rst; M_ADDR = a;
        M0_ARVALID = m0v; M1_ARVALID = m1v;
        M0_RREADY = m0r; M1_RREADY = m1r;
        arr = ar; rv = v; rl = l;
    endtask

    task automatic step;
        @(posedge clkk);
        @(negedge clkk);
    endtask

    task automatic set_windows;
        lo0 = 32'h0000_0000; hi0 = 32'h0FFF_FFFF;
        lo1 = 32'h2000_0000; hi1 = 32'h2FFF_FFFF;
        lo2 = 32'h4000_0000; hi2 = 32'h4FFF_FFFF;
        lo3 = 32'h6000_0000; hi3 = 32'h6FFF_FFFF;
    endtask

    initial begin
        set_windows();
        drive(1'b1, 32'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        step(); step();

        // Idle, reset state
        tbl.push_back(mk(0, 32'h0, 0,0,0,0, 4'h0,4'h0,4'h0, 0,2'd0,2'd0,2'd0,8'h00));
        // M0 -> S3 handshake
        tbl.push_back(mk(0, 32'h6500_0000, 1,0,0,0, 4'h8,4'h0,4'h0, 0,2'd3,2'd0,2'd0,8'h00));
        // three non-last beats
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 32'h0, 0,0,1,0, 4'h0,4'h8,4'h0, 0,2'd3,2'd3,2'd0,8'h40));
        // last beat
        tbl.push_back(mk(0, 32'h0, 0,0,1,0, 4'h0,4'h8,4'h8, 0,2'd3,2'd3,2'd0,8'h40));
        tbl.push_back(mk(0, 32'h0, 0,0,0,0, 4'h0,4'h0,4'h0, 0,2'd0,2'd0,2'd0,8'h00));
        // both request S1, M0 wins
        tbl.push_back(mk(0, 32'h2000_1000, 1,1,0,0, 4'h2,4'h0,4'h0, 0,2'd1,2'd0,2'd0,8'h00));
        // M1 still asking is ignored; non-last beat
        tbl.push_back(mk(0, 32'h2000_1000, 0,1,1,0, 4'h2,4'h2,4'h0, 0,2'd1,2'd1,2'd0,8'h04));
        // last beat for M0
        tbl.push_back(mk(0, 32'h2000_1000, 0,1,1,0, 4'h2,4'h2,4'h2, 0,2'd1,2'd1,2'd0,8'h04));
        // back-to-back: M1 granted on the Idle cycle
        tbl.push_back(mk(0, 32'h2000_1000, 0,1,0,0, 4'h2,4'h0,4'h0, 1,2'd1,2'd0,2'd0,8'h00));
        // last beat but only the non-owner is ready
        tbl.push_back(mk(0, 32'h2000_1000, 0,1,1,0, 4'h2,4'h2,4'h2, 1,2'd1,2'd0,2'd1,8'h08));
        // owner ready next cycle
        tbl.push_back(mk(0, 32'h0, 0,0,0,1, 4'h0,4'h2,4'h2, 1,2'd1,2'd0,2'd1,8'h08));
        tbl.push_back(mk(0, 32'h0, 0,0,0,0, 4'h0,4'h0,4'h0, 0,2'd0,2'd0,2'd0,8'h00));
        // S2 not ready for 4 cycles
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 32'h4500_0000, 1,0,0,0, 4'h8,4'h0,4'h0, 0,2'd2,2'd0,2'd0,8'h00));
        tbl.push_back(mk(0, 32'h4500_0000, 1,0,0,0, 4'h4,4'h0,4'h0, 0,2'd2,2'd0,2'd0,8'h00));
        tbl.push_back(mk(0, 32'h0, 0,0,0,0, 4'h0,4'h0,4'h0, 0,2'd2,2'd2,2'd0,8'h10));
        // reset mid-burst dominates a last-beat handshake
        tbl.push_back(mk(1, 32'h0, 0,0,1,0, 4'h0,4'h4,4'h4, 0,2'd2,2'd2,2'd0,8'h10));
        tbl.push_back(mk(0, 32'h0, 0,0,0,0, 4'h0,4'h0,4'h0, 0,2'd0,2'd0,2'd0,8'h00));
        // unmapped address never leaves Idle
        tbl.push_back(mk(0, 32'h9000_0000, 1,0,0,0, 4'hF,4'h0,4'h0, 0,2'd0,2'd0,2'd0,8'h00));
        tbl.push_back(mk(0, 32'h0, 0,0,0,0, 4'h0,4'h0,4'h0, 0,2'd0,2'd0,2'd0,8'h00));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].addr, tbl[i].m0v, tbl[i].m1v,
                  tbl[i].m0r, tbl[i].m1r, tbl[i].arr, tbl[i].rv, tbl[i].rl);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].sm, tbl[i].ss,
                       tbl[i].d0, tbl[i].d1, tbl[i].en);
            step();
        end

        // empty S2 window: address falls nowhere
        lo2 = 32'h5000_0000; hi2 = 32'h4FFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h4500_0000, 1, 0, 0, 0, 4'hF, 4'h0, 4'h0);
            #1;
            check_outs($sformatf("empty%0d", i), 0, 2'd0, 2'd0, 2'd0, 8'h00);
            step();
        end
        drive(0, 32'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        #1;
        check_outs("empty_idle", 0, 2'd0, 2'd0, 2'd0, 8'h00);
        set_windows();
        step();

        // overlapping S1/S2 windows: lower index wins
        hi1 = 32'h4FFF_FFFF;
        drive(0, 32'h4500_0000, 0, 1, 0, 0, 4'hF, 4'h0, 4'h0);
        #1;
        check_outs("ovl_req", 1, 2'd1, 2'd0, 2'd0, 8'h00);
        step();
        drive(0, 32'h0, 0, 0, 0, 1, 4'h0, 4'h2, 4'h2);
        #1;
        check_outs("ovl_burst", 1, 2'd1, 2'd0, 2'd1, 8'h08);
        step();
        drive(0, 32'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        #1;
        check_outs("ovl_done", 0, 2'd0, 2'd0, 2'd0, 8'h00);
        set_windows();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
